seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit adder cells.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through one shared CHUNK-bit ripple-carry slice.
- Trades latency for area.
- Sits behind a start/busy/done handshake, so the datapath, controller or ALU wrapper launches an operation and later collects sum, carry-out and signed overflow.

Parameters:
- WIDTH, 64: operand and result width in bits.
- CHUNK, 16: bits processed per cycle. WIDTH must be an integer multiple of CHUNK; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at clk edge, accepted only when busy=0
- sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored)
- cin  input  1  carry-in for add mode
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next done
- cout  output  1  final carry-out; in sub mode 1 means no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- NCH = WIDTH/CHUNK.
- Reset (rst_n low, any time, including mid-operation):
  - state IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Chunk counter and operand registers cleared.
  - The in-flight operation is discarded; no done follows.
- FSM states:
  - IDLE: busy=0. On an edge with start=1:
    - latch a, b^{WIDTH{sub}} and carry (sub ? 1 : cin);
    - set cnt=0;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - slice cnt adds the operand chunk plus the carry register;
    - the result chunk is written into the partial-sum register at position cnt;
    - the carry register takes the slice carry-out;
    - cnt increments.
  - Last RUN cycle (cnt=NCH-1): the same edge does all of the following:
    - loads sum with the full result;
    - loads cout with the slice carry-out;
    - loads ovf = carry into MSB XOR carry out of MSB;
    - pulses done=1;
    - drops busy to 0;
    - returns to IDLE.
- Latency:
  - start accepted at edge k → done high for the cycle after edge k+NCH.
  - busy high for exactly NCH cycles.
  - CHUNK=WIDTH gives latency 1.
- start while busy=1 is ignored; no queueing, operands unchanged.
- Back-to-back: start=1 in the cycle done=1 (busy=0) is accepted. done falls and busy rises at the same edge.
- sum/cout/ovf change only on the done edge or on reset. They are stable while busy, holding the previous result.
- Operands a, b, sub and cin may change freely after accept.
- Ripple order is LSB chunk first. Carry crosses chunk boundaries through the carry register, never combinationally.
- Arithmetic is modulo 2^WIDTH.
- The counter is ceil(log2(NCH)) bits, minimum 1. It never wraps in normal operation.

Decomposition:
- Shared package adder_pkg:
  - state encoding constants (IDLE=0, RUN=1);
  - helper function for counter width (clog2 with minimum 1).
- One natural sub-module, rca_chunk: combinational CHUNK-bit ripple-carry slice built from full-adder cells.
  - Ports: a, b, ci, s, co, plus c_msb_in (carry into its top bit) for overflow detection.
- Controller, registers and overflow logic stay in seq_chunk_adder.

Test Plan (WIDTH=64, CHUNK=16, NCH=4 unless stated):
- Add wrap: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 → done exactly 4 cycles after accept, sum=0, cout=1, ovf=0; busy high 4 cycles.
- Chunk-boundary carry: a=0000_0000_0000_FFFF, b=0, cin=1 → sum=0000_0000_0001_0000, cout=0. Then a=7FFF_FFFF_FFFF_FFFF, b=1 → sum=8000_0000_0000_0000, ovf=1, cout=0.
- Subtract: sub=1, a=5, b=7 → sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=8000_0000_0000_0000, b=1 → sum=7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Handshake:
  - start pulsed at busy cycle 2 with different operands → ignored, first result unchanged;
  - start held in the done cycle → second op accepted, its done 4 cycles later, no idle gap.
- Reset mid-operation: assert rst_n=0 asynchronously during RUN cnt=2 → busy, done, sum, cout, ovf all 0 immediately; after release no done pulse appears until a new start.
- Parameter sweep: CHUNK=64 → latency 1; CHUNK=8 → latency 8. Random a/b/sub/cin, ≥1000 vectors each, compared against a+b+cin / a-b reference model.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the sequential chunked adder.
//   state_e     : controller state encoding (IDLE=0, RUN=1)
//   cnt_width() : chunk-counter width, clog2 with a floor of one bit
//   full_add()  : one full-adder cell, returns {carry_out, sum}
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational W-bit ripple-carry slice built from full-adder cells.
//   a, b      : slice operands
//   ci        : carry into bit 0
//   s         : slice sum
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow)
module rca_chunk
  import adder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic       c_v;
  logic [1:0] fa_v;

  // Ripple the carry through the full-adder cells, LSB first.
  always_comb begin
    c_v  = ci;
    fa_v = 2'b00;
    s    = '0;
    for (int i = 0; i < W; i++) begin
      fa_v = full_add(a[i], b[i], c_v);
      s[i] = fa_v[0];
      c_v  = fa_v[1];
    end
    co = c_v;
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
    c_msb_in = s[W-1] ^ a[W-1] ^ b[W-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed CHUNK bits
// per clock through one shared ripple-carry slice, behind a start/busy/done
// handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : launch request, accepted only while busy=0
//   sub, cin        : 0: a+b+cin, 1: a-b (cin ignored)
//   a, b            : operands, captured on accept
//   busy            : operation in progress
//   done            : one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf  : result, carry-out (sub: 1 = no borrow), signed overflow
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_width(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] op_a_s, op_b_s, slice_s;
  logic             slice_co, slice_cmsb;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    for (int i = 0; i < NCH; i++) begin
      op_a_s = (cnt_q == CW'(i)) ? a_q[i*CHUNK +: CHUNK] : op_a_s;
      op_b_s = (cnt_q == CW'(i)) ? b_q[i*CHUNK +: CHUNK] : op_b_s;
    end
  end

  rca_chunk #(.W(CHUNK)) u_slice (
    .a        (op_a_s),
    .b        (op_b_s),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_cmsb)
  );

  // Controller next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction is a + ~b + 1: invert b here, force the carry-in.
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NCH; i++) begin
          part_d[i*CHUNK +: CHUNK] = (cnt_q == CW'(i)) ? slice_s : part_q[i*CHUNK +: CHUNK];
        end
        carry_d = slice_co;
        if (cnt_q == LAST) begin
          // part_d already holds the final chunk, so it is the full result.
          sum_d   = part_d;
          cout_d  = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and random checks of seq_chunk_adder with CHUNK = 16, 64 and 8.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, cin;
  logic [63:0] a, b;

  logic        busy_m, done_m, cout_m, ovf_m;
  logic [63:0] sum_m;
  logic        busy_w, done_w, cout_w, ovf_w;
  logic [63:0] sum_w;
  logic        busy_n, done_n, cout_n, ovf_n;
  logic [63:0] sum_n;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_m, lat_w, lat_n, busy_cnt;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_m), .done(done_m), .sum(sum_m), .cout(cout_m), .ovf(ovf_m));

  seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w));

  seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_n), .done(done_n), .sum(sum_n), .cout(cout_n), .ovf(ovf_n));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} computed with plain wide arithmetic.
  function automatic logic [65:0] ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                             input logic rsub, input logic rcin);
    logic [63:0] b2;
    logic [64:0] r;
    logic        v;
    b2 = rsub ? ~rb : rb;
    r  = {1'b0, ra} + {1'b0, b2} + {64'd0, (rsub ? 1'b1 : rcin)};
    v  = (ra[63] == b2[63]) && (r[63] != ra[63]);
    return {v, r[64], r[63:0]};
  endfunction

  // Launch one operation on all three DUTs and measure each latency.
  task automatic do_op(input logic [63:0] ia, input logic [63:0] ib,
                       input logic isub, input logic icin);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands may change freely after accept.
    a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
    lat_m = -1; lat_w = -1; lat_n = -1; busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy_m) busy_cnt++;
      if (done_m && lat_m < 0) lat_m = n - 1;
      if (done_w && lat_w < 0) lat_w = n - 1;
      if (done_n && lat_n < 0) lat_n = n - 1;
      @(posedge clk); #1;
      if (lat_m >= 0 && lat_w >= 0 && lat_n >= 0) break;
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] es, input logic ec, input logic eo);
    chk({tag, " lat16"}, 64'(lat_m), 64'd4);
    chk({tag, " busy16"}, 64'(busy_cnt), 64'd4);
    chk({tag, " lat64"}, 64'(lat_w), 64'd1);
    chk({tag, " lat8"}, 64'(lat_n), 64'd8);
    chk({tag, " sum16"}, sum_m, es);
    chk({tag, " cout16"}, {63'd0, cout_m}, {63'd0, ec});
    chk({tag, " ovf16"}, {63'd0, ovf_m}, {63'd0, eo});
    chk({tag, " sum64"}, sum_w, es);
    chk({tag, " sum8"}, sum_n, es);
    chk({tag, " flags64"}, {62'd0, cout_w, ovf_w}, {62'd0, ec, eo});
    chk({tag, " flags8"}, {62'd0, cout_n, ovf_n}, {62'd0, ec, eo});
  endtask

  logic [65:0] exp_r;
  int          done_seen;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    tbl[1] = '{64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    tbl[7] = '{64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 64'd0; b = 64'd0;
    #3;
    chk("reset busy/done", {62'd0, busy_m, done_m}, 64'd0);
    chk("reset sum", sum_m, 64'd0);
    chk("reset cout/ovf", {62'd0, cout_m, ovf_m}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
      chk_all($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
    end

    // start while busy is ignored.
    a = 64'd100; b = 64'd23; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;               // busy cycle 1
    @(posedge clk); #1;                            // busy cycle 2
    a = 64'd5; b = 64'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;               // busy cycle 3
    @(posedge clk); #1;                            // busy cycle 4
    chk("ign busy4", {63'd0, busy_m}, 64'd1);
    @(posedge clk); #1;
    chk("ign done", {62'd0, done_m, busy_m}, 64'd2);
    chk("ign sum", sum_m, 64'd123);
    @(posedge clk); #1;
    chk("ign no second op", {62'd0, done_m, busy_m}, 64'd0);

    // Back-to-back: start held in the done cycle.
    a = 64'd1; b = 64'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(posedge clk); #1;
    chk("b2b done1", {62'd0, done_m, busy_m}, 64'd2);
    chk("b2b sum1", sum_m, 64'd3);
    a = 64'd10; b = 64'd20; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("b2b no gap", {62'd0, done_m, busy_m}, 64'd1);
    chk("b2b sum held", sum_m, 64'd3);
    repeat (3) @(posedge clk);
    #1;
    @(posedge clk); #1;
    chk("b2b done2", {62'd0, done_m, busy_m}, 64'd2);
    chk("b2b sum2", sum_m, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("b2b flags2", {62'd0, cout_m, ovf_m}, 64'd0);

    // Give all instances time to finish before the reset test.
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset during RUN with cnt=2.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;               // cnt=0
    @(posedge clk); #1;                            // cnt=1
    @(posedge clk); #1;                            // cnt=2
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy/done", {62'd0, busy_m, done_m}, 64'd0);
    chk("rst sum", sum_m, 64'd0);
    chk("rst cout/ovf", {62'd0, cout_m, ovf_m}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_m || busy_m) done_seen++;
    end
    chk("rst no done", 64'(done_seen), 64'd0);
    @(posedge clk); #1;

    // Random sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra, rb;
      logic        rs, rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      exp_r = ref_model(ra, rb, rs, rc);
      do_op(ra, rb, rs, rc);
      chk_all($sformatf("rnd%0d", i), exp_r[63:0], exp_r[64], exp_r[65]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
